// File: rtl/gate_check_pkg.sv
// Shared definitions for the two-input gate checkers: FSM encoding, the
// expected response of each input vector and the response bit positions.
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Response bit order is {ny, ay, nay, oy, noy, xoy, xny}.
    localparam int BIT_NY  = 6;
    localparam int BIT_AY  = 5;
    localparam int BIT_NAY = 4;
    localparam int BIT_OY  = 3;
    localparam int BIT_NOY = 2;
    localparam int BIT_XOY = 1;
    localparam int BIT_XNY = 0;

    localparam logic [6:0] EXP_V00 = 7'b1010101;
    localparam logic [6:0] EXP_V01 = 7'b1011010;
    localparam logic [6:0] EXP_V10 = 7'b0011010;
    localparam logic [6:0] EXP_V11 = 7'b0101001;

endpackage

// File: rtl/gate_ref_model.sv
// Truth-table reference for the seven basic gates, indexed by {a,b}.
module gate_ref_model
    import gate_check_pkg::*;
(
    input  logic [1:0] vec,
    output logic [6:0] expected
);

    always_comb begin
        expected = EXP_V00;
        case (vec)
            2'b00: expected = EXP_V00;
            2'b01: expected = EXP_V01;
            2'b10: expected = EXP_V10;
            2'b11: expected = EXP_V11;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Walks all four {a,b} vectors through a gate unit, waits SETTLE_CYCLES per
// vector, and compares the sampled responses against gate_ref_model.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       ny_in,
    input  logic       ay_in,
    input  logic       nay_in,
    input  logic       oy_in,
    input  logic       noy_in,
    input  logic       xoy_in,
    input  logic       xny_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [6:0] fail_mask,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    state_t           r_state;
    logic [1:0]       r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [2:0]       r_err_count;
    logic [6:0]       r_fail_mask;
    logic [1:0]       r_first_fail_vec;
    logic             r_first_fail_valid;

    logic [6:0]       w_expected;
    logic [6:0]       w_response;
    logic [6:0]       w_mism;

    gate_ref_model u_ref (
        .vec      (r_vec),
        .expected (w_expected)
    );

    always_comb begin
        w_response          = '0;
        w_response[BIT_NY]  = ny_in;
        w_response[BIT_AY]  = ay_in;
        w_response[BIT_NAY] = nay_in;
        w_response[BIT_OY]  = oy_in;
        w_response[BIT_NOY] = noy_in;
        w_response[BIT_XOY] = xoy_in;
        w_response[BIT_XNY] = xny_in;
    end

    assign w_mism = w_response ^ w_expected;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_vec              <= '0;
            r_cnt              <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_err_count        <= '0;
            r_fail_mask        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state            <= ST_SETTLE;
                        r_vec              <= 2'b00;
                        r_cnt              <= SETTLE_LOAD;
                        r_busy             <= 1'b1;
                        r_done             <= 1'b0;
                        r_pass             <= 1'b0;
                        r_err_count        <= '0;
                        r_fail_mask        <= '0;
                        r_first_fail_vec   <= '0;
                        r_first_fail_valid <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_fail_mask <= r_fail_mask | w_mism;
                    if (w_mism != '0) begin
                        r_err_count <= r_err_count + 3'd1;
                        if (!r_first_fail_valid) begin
                            r_first_fail_vec   <= r_vec;
                            r_first_fail_valid <= 1'b1;
                        end
                    end
                    if (r_vec == 2'b11) begin
                        // pass must already be right on the edge done rises,
                        // so fold in this final sample directly.
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == 3'd0) && (w_mism == '0);
                    end else begin
                        r_state <= ST_SETTLE;
                        r_vec   <= r_vec + 2'd1;
                        r_cnt   <= SETTLE_LOAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign a_out            = r_vec[1];
    assign b_out            = r_vec[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign fail_mask        = r_fail_mask;
    assign first_fail_vec   = r_first_fail_vec;
    assign first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a behavioural gate unit with injectable
// faults drives two checker instances (settle 1 and settle 3).
module tb_gate_vector_checker;

    typedef struct {
        logic       pass;
        int         err;
        logic [6:0] mask;
        logic [1:0] ffv;
        logic       ffvalid;
    } res_t;

    typedef struct {
        int   fault;
        res_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start1, start3;
    int   fault1, fault3;
    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];

    always #5 clk = ~clk;

    // Independent gate-equation model; fault 1 = ay stuck 0, fault 2 = xoy inverted.
    function automatic logic [6:0] gate_resp(input logic a, input logic b, input int fault);
        logic [6:0] r;
        r = {~a, a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b)};
        if (fault == 1) r[5] = 1'b0;
        if (fault == 2) r[1] = ~r[1];
        return r;
    endfunction

    logic       a1, b1, busy1, done1, pass1, ffvalid1;
    logic [2:0] err1;
    logic [6:0] mask1, resp1;
    logic [1:0] ffv1;
    logic       a3, b3, busy3, done3, pass3, ffvalid3;
    logic [2:0] err3;
    logic [6:0] mask3, resp3;
    logic [1:0] ffv3;

    assign resp1 = gate_resp(a1, b1, fault1);
    assign resp3 = gate_resp(a3, b3, fault3);

    gate_vector_checker #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
        .ny_in(resp1[6]), .ay_in(resp1[5]), .nay_in(resp1[4]), .oy_in(resp1[3]),
        .noy_in(resp1[2]), .xoy_in(resp1[1]), .xny_in(resp1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_mask(mask1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
    );

    gate_vector_checker #(.SETTLE_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3),
        .ny_in(resp3[6]), .ay_in(resp3[5]), .nay_in(resp3[4]), .oy_in(resp3[3]),
        .noy_in(resp3[2]), .xoy_in(resp3[1]), .xny_in(resp3[0]),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_mask(mask3), .first_fail_vec(ffv3), .first_fail_valid(ffvalid3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, " a/b"}, int'({a1, b1}), 0);
        chk({tag, " busy"}, int'(busy1), 0);
        chk({tag, " done"}, int'(done1), 0);
        chk({tag, " pass"}, int'(pass1), 0);
        chk({tag, " err_count"}, int'(err1), 0);
        chk({tag, " fail_mask"}, int'(mask1), 0);
        chk({tag, " first_fail_vec"}, int'(ffv1), 0);
        chk({tag, " first_fail_valid"}, int'(ffvalid1), 0);
    endtask

    // One full run on dut1; expected results queued at start, compared at done.
    task automatic run1(input int fault, input res_t exp);
        int   n;
        res_t e;
        fault1 = fault;
        sb_q.push_back(exp);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("run start busy", int'(busy1), 1);
        chk("run start done", int'(done1), 0);
        chk("run start err_count cleared", int'(err1), 0);
        chk("run start fail_mask cleared", int'(mask1), 0);
        chk("run start ffvalid cleared", int'(ffvalid1), 0);
        n = 0;
        while (!done1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!done1) begin
            chk("run done timeout", 0, 1);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            chk("run latency edges", n, 8);
            chk("run busy at done", int'(busy1), 0);
            chk("run pass", int'(pass1), int'(e.pass));
            chk("run err_count", int'(err1), e.err);
            chk("run fail_mask", int'(mask1), int'(e.mask));
            chk("run first_fail_valid", int'(ffvalid1), int'(e.ffvalid));
            if (e.ffvalid) chk("run first_fail_vec", int'(ffv1), int'(e.ffv));
            $display("run fault=%0d edges=%0d pass=%0b err=%0d mask=%b ffv=%b ffvalid=%0b",
                     fault, n, pass1, err1, mask1, ffv1, ffvalid1);
            @(negedge clk);
            chk("run done held", int'(done1), 1);
            chk("run err_count held", int'(err1), e.err);
        end
    endtask

    initial begin
        vec_t tbl[4];
        tbl[0] = '{fault: 0, exp: '{pass: 1'b1, err: 0, mask: 7'b0000000, ffv: 2'b00, ffvalid: 1'b0}};
        tbl[1] = '{fault: 1, exp: '{pass: 1'b0, err: 1, mask: 7'b0100000, ffv: 2'b11, ffvalid: 1'b1}};
        tbl[2] = '{fault: 2, exp: '{pass: 1'b0, err: 4, mask: 7'b0000010, ffv: 2'b00, ffvalid: 1'b1}};
        tbl[3] = '{fault: 0, exp: '{pass: 1'b1, err: 0, mask: 7'b0000000, ffv: 2'b00, ffvalid: 1'b0}};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; fault1 = 0; fault3 = 0;
        repeat (3) @(negedge clk);
        chk_reset1("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run1(tbl[i].fault, tbl[i].exp);

        // Settle 3: a/b walk 00,01,10,11 four cycles each; starts at edges 2 and 9 ignored.
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("s3 a/b edge %0d", n), int'({a3, b3}), n / 4);
            chk($sformatf("s3 busy edge %0d", n), int'(busy3), 1);
            start3 = (n == 1 || n == 8);
            @(negedge clk);
        end
        start3 = 1'b0;
        chk("s3 done after edge 16", int'(done3), 1);
        chk("s3 pass", int'(pass3), 1);
        chk("s3 err_count", int'(err3), 0);
        $display("s3 run done=%0b pass=%0b err=%0d mask=%b", done3, pass3, err3, mask3);

        // Reset at edge 5 of a run, then a clean re-run.
        fault1 = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset1("midrun reset");
        $display("midrun reset applied busy=%0b done=%0b", busy1, done1);
        run1(tbl[0].fault, tbl[0].exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
